// File: rtl/adder_bench_pkg.sv
// rtl/adder_bench_pkg.sv - shared types, constants and LFSR step for the adder stimulus checker
package adder_bench_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_A = 32'hACE1_2468;
  localparam logic [31:0] LFSR_SEED_B = 32'h1357_9BDF;
  localparam int          ERR_W       = 16;

  // One Galois step: shift right, fold the mask in when the bit shifted out is set.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// rtl/lfsr32_galois.sv - 32-bit Galois LFSR with synchronous reload and step enable
module lfsr32_galois
  import adder_bench_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // Reload wins over step so a restart always begins from the seed.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  // State register; reset lands on the same seed a reload would use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/adder_stim_checker.sv
// rtl/adder_stim_checker.sv - drives adder operands and checks the returned sum after LATENCY cycles
module adder_stim_checker
  import adder_bench_pkg::*;
#(
  parameter int ADDER_WIDTH = 96,
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  input  logic [ADDER_WIDTH:0]   sum,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [31:0]            vec_count
);

  localparam int                DRAIN_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);
  localparam logic [31:0]       VEC_TOTAL  = 32'(NUM_VECTORS);
  localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};

  state_e                 state_q, state_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d;
  logic [ADDER_WIDTH-1:0] b_q, b_d;
  logic [31:0]            vec_q, vec_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;

  logic                   start_ok;
  logic                   more_vec;
  logic                   issue;
  logic [31:0]            vec_idx;
  logic                   lfsr_step;
  logic [31:0]            lfsr_a, lfsr_b;
  logic [31:0]            word_a, word_b;
  logic [ADDER_WIDTH-1:0] a_shift, b_shift;
  logic [ADDER_WIDTH:0]   exp_now;
  logic                   vld_now;
  logic [ADDER_WIDTH:0]   chk_exp;
  logic                   chk_vld;

  // start is only honoured when no run is in flight.
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign more_vec  = (vec_q != VEC_TOTAL);
  assign issue     = start_ok || ((state_q == ST_RUN) && more_vec);
  // The start edge issues v0; in RUN the issued count is the next index.
  assign vec_idx   = start_ok ? 32'd0 : vec_q;
  assign lfsr_step = issue && (vec_idx >= 32'd2);

  lfsr32_galois #(
    .RESET_SEED(LFSR_SEED_A)
  ) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (LFSR_SEED_A),
    .step (lfsr_step),
    .q    (lfsr_a)
  );

  lfsr32_galois #(
    .RESET_SEED(LFSR_SEED_B)
  ) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (LFSR_SEED_B),
    .step (lfsr_step),
    .q    (lfsr_b)
  );

  // The operand takes the already-stepped word, matching the LFSR register update.
  assign word_a = lfsr_next(lfsr_a);
  assign word_b = lfsr_next(lfsr_b);

  if (ADDER_WIDTH > 32) begin : g_wide
    assign a_shift = {a_q[ADDER_WIDTH-33:0], word_a};
    assign b_shift = {b_q[ADDER_WIDTH-33:0], word_b};
  end else begin : g_narrow
    assign a_shift = word_a[ADDER_WIDTH-1:0];
    assign b_shift = word_b[ADDER_WIDTH-1:0];
  end

  // Next-state decode: RUN lasts until every vector is on the bus, DRAIN waits out the adder.
  always_comb begin
    state_d = state_q;
    drain_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!more_vec) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and vector-count update; operands hold whenever nothing is issued.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    vec_d = vec_q;
    if (issue) begin
      vec_d = start_ok ? 32'd1 : vec_q + 32'd1;
      if (vec_idx == 32'd0) begin
        a_d = '1;
        b_d = ADDER_WIDTH'(1);
      end else if (vec_idx == 32'd1) begin
        a_d = '1;
        b_d = '1;
      end else begin
        a_d = a_shift;
        b_d = b_shift;
      end
    end
  end

  // Expected sum of the operands currently on the bus; valid only while they belong to a run.
  assign exp_now = {1'b0, a_q} + {1'b0, b_q};
  assign vld_now = (state_q == ST_RUN);

  for (genvar i = 0; i < LATENCY; i++) begin : g_exp
    logic [ADDER_WIDTH:0] exp_in;
    logic                 vld_in;
    logic [ADDER_WIDTH:0] exp_q;
    logic                 vld_q;

    if (i == 0) begin : g_head
      assign exp_in = exp_now;
      assign vld_in = vld_now;
    end else begin : g_tail
      assign exp_in = g_exp[i-1].exp_q;
      assign vld_in = g_exp[i-1].vld_q;
    end

    // One stage of the expected-value delay line, aligned with the adder pipeline.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        exp_q <= '0;
        vld_q <= 1'b0;
      end else begin
        exp_q <= exp_in;
        vld_q <= vld_in;
      end
    end
  end

  assign chk_exp = g_exp[LATENCY-1].exp_q;
  assign chk_vld = g_exp[LATENCY-1].vld_q;

  // Error counter: cleared by an accepted start, saturates instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (start_ok) begin
      err_d = '0;
    end else if (chk_vld && (sum != chk_exp) && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      drain_q <= drain_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb/tb_adder_stim_checker.sv - scoreboard bench for adder_stim_checker with an ideal 2-cycle adder
module tb_adder_stim_checker;

  localparam int W     = 96;
  localparam int L     = 2;
  localparam int N     = 16;
  localparam int N_SAT = 65540;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start_s;
  logic [W-1:0]  a, b, a_s, b_s;
  logic [W:0]    sum, sum_s;
  logic          busy, done, pass;
  logic          busy_s, done_s, pass_s;
  logic [15:0]   err_count, err_s;
  logic [31:0]   vec_count, vec_s;

  logic [W:0]    s1, s2;
  logic          flip_v5;
  int            cyc;

  logic [W-1:0]  qa[$];
  logic [W-1:0]  qb[$];

  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  adder_stim_checker #(.ADDER_WIDTH(W), .LATENCY(L), .NUM_VECTORS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sum(sum),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_count(vec_count)
  );

  adder_stim_checker #(.ADDER_WIDTH(W), .LATENCY(L), .NUM_VECTORS(N_SAT)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s), .sum(sum_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .vec_count(vec_s)
  );

  assign sum_s = '0;
  assign sum   = s2;

  // Ideal registered adder (2 cycles) with optional bit-0 fault on the v5 operands.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      cyc <= 0;
    end else begin
      s1 <= ({1'b0, a} + {1'b0, b}) ^ {{W{1'b0}}, (flip_v5 && cyc == 6)};
      s2 <= s1;
      if (start && !busy) cyc <= 1;
      else if (cyc != 0) cyc <= cyc + 1;
    end
  end

  // Scoreboard: pop one expected operand pair per RUN cycle.
  always @(negedge clk) begin
    logic [W-1:0] ea, eb;
    if (rst === 1'b0 && busy === 1'b1 && cyc >= 1 && cyc <= N) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow cyc=%0d a=%h b=%h", cyc, a, b);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        if (a !== ea || b !== eb) begin
          errors++;
          $display("FAIL vector cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, a, b, ea, eb);
        end
      end
    end
  end

  task automatic push_run();
    logic [W-1:0] ma, mb;
    logic [31:0]  la, lb;
    la = 32'hACE1_2468;
    lb = 32'h1357_9BDF;
    ma = '1; mb = 1;
    qa.push_back(ma); qb.push_back(mb);
    ma = '1; mb = '1;
    qa.push_back(ma); qb.push_back(mb);
    for (int k = 2; k < N; k++) begin
      la = (la >> 1) ^ (la[0] ? 32'h8020_0003 : 32'h0);
      lb = (lb >> 1) ^ (lb[0] ? 32'h8020_0003 : 32'h0);
      ma = {ma[W-33:0], la};
      mb = {mb[W-33:0], lb};
      qa.push_back(ma); qb.push_back(mb);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start_s = 1'b0; flip_v5 = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a !== '0)         begin errors++; $display("FAIL rst_a got=%h want=0", a); end
    checks++; if (b !== '0)         begin errors++; $display("FAIL rst_b got=%h want=0", b); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0)    begin errors++; $display("FAIL rst_pass got=%b want=0", pass); end
    checks++; if (err_count !== 0)  begin errors++; $display("FAIL rst_err got=%0d want=0", err_count); end
    checks++; if (vec_count !== 0)  begin errors++; $display("FAIL rst_vec got=%0d want=0", vec_count); end
  endtask

  task automatic test_clean_run();
    int         nb;
    bit         seen;
    logic [W:0] corner;
    logic [W-1:0] ones;
    corner = {1'b1, {W{1'b0}}};
    ones   = '1;
    push_run();
    pulse_start();
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (cyc == 1) begin
        checks++;
        if (a !== ones || b !== W'(1)) begin errors++; $display("FAIL corner_ops got a=%h b=%h", a, b); end
      end
      if (cyc == 3) begin
        checks++;
        if (sum !== corner) begin errors++; $display("FAIL corner_sum got=%h want=%h", sum, corner); end
      end
      if (cyc == 4) begin
        checks++;
        if (err_count !== 0) begin errors++; $display("FAIL corner_err got=%0d want=0", err_count); end
      end
      if (done) seen = 1'b1;
    end
    checks++; if (!seen)             begin errors++; $display("FAIL clean_timeout got=0 want=1"); end
    checks++; if (nb !== N + L)      begin errors++; $display("FAIL clean_busy got=%0d want=%0d", nb, N + L); end
    checks++; if (err_count !== 0)   begin errors++; $display("FAIL clean_err got=%0d want=0", err_count); end
    checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL clean_pass got=%b want=1", pass); end
    checks++; if (vec_count !== N)   begin errors++; $display("FAIL clean_vec got=%0d want=%0d", vec_count, N); end
    checks++; if (qa.size() !== 0)   begin errors++; $display("FAIL clean_sb_left got=%0d want=0", qa.size()); end
  endtask

  task automatic test_start_ignored();
    int nb;
    bit seen;
    push_run();
    pulse_start();
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (cyc == 5 || cyc == 17) start = 1'b1;
      else start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checks++; if (!seen)            begin errors++; $display("FAIL ign_timeout got=0 want=1"); end
    checks++; if (nb !== N + L)     begin errors++; $display("FAIL ign_busy got=%0d want=%0d", nb, N + L); end
    checks++; if (err_count !== 0)  begin errors++; $display("FAIL ign_err got=%0d want=0", err_count); end
    checks++; if (vec_count !== N)  begin errors++; $display("FAIL ign_vec got=%0d want=%0d", vec_count, N); end
    checks++; if (qa.size() !== 0)  begin errors++; $display("FAIL ign_sb_left got=%0d want=0", qa.size()); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1)    begin errors++; $display("FAIL ign_done_hold got=%b want=1", done); end
  endtask

  task automatic test_fault();
    int nb;
    bit seen;
    flip_v5 = 1'b1;
    push_run();
    pulse_start();
    wait_done(nb, seen);
    flip_v5 = 1'b0;
    checks++; if (!seen)            begin errors++; $display("FAIL fault_timeout got=0 want=1"); end
    checks++; if (err_count !== 1)  begin errors++; $display("FAIL fault_err got=%0d want=1", err_count); end
    checks++; if (pass !== 1'b0)    begin errors++; $display("FAIL fault_pass got=%b want=0", pass); end
    checks++; if (vec_count !== N)  begin errors++; $display("FAIL fault_vec got=%0d want=%0d", vec_count, N); end
  endtask

  task automatic test_restart_from_done();
    int nb;
    bit seen;
    push_run();
    pulse_start();
    @(negedge clk);
    checks++; if (err_count !== 0)  begin errors++; $display("FAIL restart_err_clr got=%0d want=0", err_count); end
    checks++; if (vec_count !== 1)  begin errors++; $display("FAIL restart_vec_clr got=%0d want=1", vec_count); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL restart_busy got=%b want=1", busy); end
    wait_done(nb, seen);
    checks++; if (!seen)              begin errors++; $display("FAIL restart_timeout got=0 want=1"); end
    checks++; if (nb !== N + L - 1)   begin errors++; $display("FAIL restart_busy_len got=%0d want=%0d", nb, N + L - 1); end
    checks++; if (pass !== 1'b1)      begin errors++; $display("FAIL restart_pass got=%b want=1", pass); end
    checks++; if (vec_count !== N)    begin errors++; $display("FAIL restart_vec got=%0d want=%0d", vec_count, N); end
    checks++; if (qa.size() !== 0)    begin errors++; $display("FAIL restart_sb_left got=%0d want=0", qa.size()); end
  endtask

  task automatic test_reset_mid_run();
    int nb;
    bit seen;
    bit hit;
    push_run();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (cyc == 7) hit = 1'b1;
    end
    checks++; if (!hit || busy !== 1'b1) begin errors++; $display("FAIL mid_reach got busy=%b want=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a !== '0 || b !== '0) begin errors++; $display("FAIL mid_ops got a=%h b=%h want 0", a, b); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("FAIL mid_flags got busy=%b done=%b pass=%b want 0", busy, done, pass);
    end
    checks++; if (err_count !== 0 || vec_count !== 0) begin
      errors++; $display("FAIL mid_counts got err=%0d vec=%0d want 0", err_count, vec_count);
    end
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    push_run();
    pulse_start();
    wait_done(nb, seen);
    checks++; if (!seen)             begin errors++; $display("FAIL mid_rerun_timeout got=0 want=1"); end
    checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL mid_rerun_pass got=%b want=1", pass); end
    checks++; if (qa.size() !== 0)   begin errors++; $display("FAIL mid_rerun_sb_left got=%0d want=0", qa.size()); end
  endtask

  task automatic test_saturation();
    int nb;
    bit seen;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    nb = 0; seen = 1'b0;
    for (int i = 0; i < N_SAT + 100 && !seen; i++) begin
      @(negedge clk);
      if (busy_s) nb++;
      if (done_s) seen = 1'b1;
    end
    checks++; if (!seen)               begin errors++; $display("FAIL sat_timeout got=0 want=1"); end
    checks++; if (nb !== N_SAT + L)    begin errors++; $display("FAIL sat_busy got=%0d want=%0d", nb, N_SAT + L); end
    checks++; if (err_s !== 16'hFFFF)  begin errors++; $display("FAIL sat_err got=%h want=ffff", err_s); end
    checks++; if (pass_s !== 1'b0)     begin errors++; $display("FAIL sat_pass got=%b want=0", pass_s); end
    checks++; if (vec_s !== N_SAT)     begin errors++; $display("FAIL sat_vec got=%0d want=%0d", vec_s, N_SAT); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_start_ignored();
    test_fault();
    test_restart_from_done();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
